// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding-select constants and FSM state type for hazard_ctrl
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and multi-cycle stall control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int FWD_EN = 1,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_d,
  input  logic [ADDR_W-1:0] rs2_d,
  input  logic [ADDR_W-1:0] rs1_e,
  input  logic [ADDR_W-1:0] rs2_e,
  input  logic [ADDR_W-1:0] rd_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memread_e,
  input  logic              pcsrc_e,
  input  logic              mc_start_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MC_W = ($clog2(MC_LAT) > 3) ? $clog2(MC_LAT) : 3;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 2);

  hz_state_t       state;
  logic [MC_W-1:0] mc_cnt;
  logic            mc_act;
  logic            dstall;

  function automatic logic match(input logic [ADDR_W-1:0] rs,
                                 input logic [ADDR_W-1:0] rd,
                                 input logic              we);
    return we && (rd == rs) && (rd != '0);
  endfunction

  // The final MC_WAIT cycle (mc_cnt == 0) releases the stall so the op can leave E.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mc_start_e) begin
            mc_cnt <= MC_LOAD;
            state  <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - MC_W'(1);
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    mc_act = 1'b0;
    if (!rst) begin
      mc_act = (state == RUN) ? mc_start_e : (mc_cnt != '0);
    end
  end

  always_comb begin
    dstall = 1'b0;
    if (FWD_EN != 0) begin
      dstall = memread_e && (match(rs1_d, rd_e, regwrite_e) || match(rs2_d, rd_e, regwrite_e));
    end else begin
      dstall = match(rs1_d, rd_e, regwrite_e) || match(rs2_d, rd_e, regwrite_e) ||
               match(rs1_d, rd_m, regwrite_m) || match(rs2_d, rd_m, regwrite_m);
    end
  end

  // Priority: multi-cycle stall, then branch flush, then data stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst) begin
      stall_f = 1'b0;
    end else if (mc_act) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (dstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if ((FWD_EN != 0) && !rst) begin
      if (match(rs1_e, rd_m, regwrite_m))      fwd_a = FWD_M;
      else if (match(rs1_e, rd_w, regwrite_w)) fwd_a = FWD_W;
      if (match(rs2_e, rd_m, regwrite_m))      fwd_b = FWD_M;
      else if (match(rs2_e, rd_w, regwrite_w)) fwd_b = FWD_W;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_f),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_e),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against an occupancy model
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memread_e, pcsrc_e, mc_start_e;

  // instance 0: defaults, 1: stall-only with 2-bit counters, 2: MC_LAT = 2
  logic        sf [3], sd [3], se [3], fd [3], fe [3], fm [3];
  logic [1:0]  fa [3], fb [3];
  logic [15:0] sc0, fc0, sc2, fc2;
  logic [1:0]  sc1, fc1;

  hazard_ctrl u_main (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
    .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]), .flush_d(fd[0]), .flush_e(fe[0]),
    .flush_m(fm[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) u_so (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
    .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]), .flush_d(fd[1]), .flush_e(fe[1]),
    .flush_m(fm[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl #(.MC_LAT(2)) u_mc2 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
    .stall_f(sf[2]), .stall_d(sd[2]), .stall_e(se[2]), .flush_d(fd[2]), .flush_e(fe[2]),
    .flush_m(fm[2]), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  int n_chk = 0;
  int n_fail = 0;

  int fen_p [3] = '{1, 0, 1};
  int lat_p [3] = '{4, 4, 2};
  int cw_p  [3] = '{16, 2, 16};

  int occ [3] = '{0, 0, 0};
  int m_sc [3] = '{0, 0, 0};
  int m_fc [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && (rs == rd) && (rd != 5'd0);
  endfunction

  // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}, fwd = {fwd_a, fwd_b}
  task automatic model_eval(input int i, output logic [5:0] ctl, output logic [3:0] fwd);
    bit mc, ds;
    logic [1:0] a, b;
    ctl = '0;
    fwd = '0;
    if (rst) return;
    mc = (occ[i] == 0) ? mc_start_e : ((occ[i] + 1) < lat_p[i]);
    if (fen_p[i] != 0)
      ds = memread_e && (hit(rs1_d, rd_e, regwrite_e) || hit(rs2_d, rd_e, regwrite_e));
    else
      ds = hit(rs1_d, rd_e, regwrite_e) || hit(rs2_d, rd_e, regwrite_e) ||
           hit(rs1_d, rd_m, regwrite_m) || hit(rs2_d, rd_m, regwrite_m);
    if (mc)           ctl = 6'b111001;
    else if (pcsrc_e) ctl = 6'b000110;
    else if (ds)      ctl = 6'b110010;
    if (fen_p[i] != 0) begin
      a = hit(rs1_e, rd_m, regwrite_m) ? 2'd2 : hit(rs1_e, rd_w, regwrite_w) ? 2'd1 : 2'd0;
      b = hit(rs2_e, rd_m, regwrite_m) ? 2'd2 : hit(rs2_e, rd_w, regwrite_w) ? 2'd1 : 2'd0;
      fwd = {a, b};
    end
  endtask

  task automatic model_adv(input int i, input logic [5:0] ctl);
    int mx;
    if (rst) begin
      occ[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      return;
    end
    if (occ[i] == 0) occ[i] = mc_start_e ? 1 : 0;
    else occ[i] = ((occ[i] + 1) == lat_p[i]) ? 0 : occ[i] + 1;
    mx = (1 << cw_p[i]) - 1;
    if (ctl[5] && m_sc[i] < mx) m_sc[i]++;
    if (ctl[1] && m_fc[i] < mx) m_fc[i]++;
  endtask

  task automatic get_obs(input int i, output logic [5:0] ctl, output logic [3:0] fwd,
                         output logic [15:0] s, output logic [15:0] f);
    ctl = {sf[i], sd[i], se[i], fd[i], fe[i], fm[i]};
    fwd = {fa[i], fb[i]};
    case (i)
      0:       begin s = sc0; f = fc0; end
      1:       begin s = {14'd0, sc1}; f = {14'd0, fc1}; end
      default: begin s = sc2; f = fc2; end
    endcase
  endtask

  task automatic step();
    logic [5:0] ec, oc;
    logic [3:0] ef, of;
    logic [15:0] os, ofc;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      model_eval(i, ec, ef);
      get_obs(i, oc, of, os, ofc);
      check($sformatf("ctl[%0d]", i), 32'(oc), 32'(ec));
      check($sformatf("fwd[%0d]", i), 32'(of), 32'(ef));
      check($sformatf("stall_cnt[%0d]", i), 32'(os), 32'(m_sc[i]));
      check($sformatf("flush_cnt[%0d]", i), 32'(ofc), 32'(m_fc[i]));
      model_adv(i, ec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memread_e = 0; pcsrc_e = 0; mc_start_e = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    #1; check("rst_stall_f", 32'(sf[0]), 32'd0);
    step();
    step();
    rst = 1'b0;

    rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
    #1; check("fwd_m_prio", 32'(fa[0]), 32'd2);
    step();
    rd_m = 0;
    #1; check("fwd_w", 32'(fa[0]), 32'd1);
    step();
    rd_w = 0;
    #1; check("fwd_rf", 32'(fa[0]), 32'd0);
    step();

    idle();
    memread_e = 1; rd_e = 7; regwrite_e = 1; rs2_d = 7;
    #1; check("loaduse_stall", 32'({sf[0], sd[0], fe[0]}), 32'b111);
    step();
    #1; check("loaduse_scnt", 32'(sc0), 32'd1);
    check("loaduse_fcnt", 32'(fc0), 32'd1);
    rd_e = 0;
    #1; check("x0_no_stall", 32'(sf[0]), 32'd0);
    step();
    rd_e = 7; pcsrc_e = 1;
    #1; check("br_over_lu", 32'({fd[0], fe[0], sf[0]}), 32'b110);
    step();
    #1; check("br_scnt_held", 32'(sc0), 32'd1);

    idle();
    mc_start_e = 1;
    for (int c = 1; c <= 4; c++) begin
      pcsrc_e = (c == 2);
      #1; check($sformatf("mc_stall_c%0d", c), 32'({se[0], fm[0]}), (c < 4) ? 32'b11 : 32'b00);
      if (c == 2) check("mc_br_ignored", 32'(fd[0]), 32'd0);
      step();
    end

    idle();
    mc_start_e = 1;
    step();
    rst = 1;
    #1; check("rst_mid_mc", 32'({sf[0], se[0], fm[0]}), 32'd0);
    step();
    rst = 0; mc_start_e = 0;
    #1; check("post_rst_run", 32'(sf[0]), 32'd0);
    check("post_rst_cnt", 32'(sc0), 32'd0);
    step();

    idle();
    rd_m = 3; regwrite_m = 1; rs1_d = 3; rs1_e = 3;
    for (int c = 0; c < 5; c++) begin
      #1; check("so_stall", 32'({sf[1], fa[1], fb[1]}), 32'b10000);
      step();
    end
    #1; check("so_sat", 32'(sc1), 32'd3);

    for (int n = 0; n < 600; n++) begin
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
      rd_w  = 5'($urandom_range(0, 7));
      regwrite_e = 1'($urandom); regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
      memread_e  = ($urandom_range(0, 2) == 0);
      pcsrc_e    = ($urandom_range(0, 5) == 0);
      mc_start_e = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
